// File: rtl/vc_out_arbiter.sv
// Output-port VC arbiter: round-robin grant per packet, header-to-tail lock, registered flit mux.
// Optional sticky protocol-error flag err_o when VC_ARB_ERR_EN is defined.
module vc_out_arbiter #(
    parameter int unsigned IN_N      = 5,
    parameter int unsigned FLIT_W    = 10,
    parameter int unsigned FLIT_ID_W = 2,
    parameter int unsigned HEADER_ID = 2,
    parameter int unsigned TAIL_ID   = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [IN_N-1:0]          req_i,
    input  logic [IN_N*FLIT_W-1:0]   data_i,
    input  logic [IN_N-1:0]          data_vld_i,
    output logic [IN_N-1:0]          alloc_o,
    output logic [IN_N-1:0]          chan_rdy_o,
    output logic [FLIT_W-1:0]        data_o,
    output logic                     wr_en_o,
    input  logic                     rdy_i
`ifdef VC_ARB_ERR_EN
    ,
    output logic                     err_o
`endif
);

    localparam int unsigned PTR_W = (IN_N > 1) ? $clog2(IN_N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b01,
        LOCKED = 2'b10
    } state_e;

    state_e                 state_q, state_d;
    logic [IN_N-1:0]        grant_q, grant_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       winner_q, winner_d;
    logic                   fired_q, fired_d;
    logic [FLIT_W-1:0]      data_q, data_d;
    logic                   wr_en_q, wr_en_d;

    logic [FLIT_W-1:0]      sel_flit;
    logic [FLIT_ID_W-1:0]   sel_id;
    logic                   fire;
    logic                   req_held;
    logic                   found;
    logic [PTR_W-1:0]       idx;

    // Flit mux driven by the registered winner index
    always_comb begin
        sel_flit = '0;
        for (int unsigned i = 0; i < IN_N; i++) begin
            if (winner_q == PTR_W'(i)) begin
                sel_flit = data_i[i*FLIT_W +: FLIT_W];
            end
        end
    end

    assign sel_id   = sel_flit[FLIT_W-1 -: FLIT_ID_W];
    assign fire     = (state_q == LOCKED) && (|(data_vld_i & grant_q)) && rdy_i;
    assign req_held = |(req_i & grant_q);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        winner_d = winner_q;
        fired_d  = fired_q;
        data_d   = data_q;
        wr_en_d  = 1'b0;
        found    = 1'b0;
        idx      = '0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                fired_d = 1'b0;
                if (|req_i) begin
                    // Search upward from rr_ptr with wrap-around; first hit wins
                    for (int unsigned k = 0; k < IN_N; k++) begin
                        idx = PTR_W'((32'(rr_ptr_q) + k) % IN_N);
                        if (!found && req_i[idx]) begin
                            found    = 1'b1;
                            winner_d = idx;
                            grant_d  = '0;
                            grant_d[idx] = 1'b1;
                        end
                    end
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (fire) begin
                    wr_en_d = 1'b1;
                    data_d  = sel_flit;
                    fired_d = 1'b1;
                    if (sel_id == FLIT_ID_W'(TAIL_ID)) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        fired_d  = 1'b0;
                        rr_ptr_d = (winner_q == PTR_W'(IN_N - 1)) ? '0 : winner_q + PTR_W'(1);
                    end
                end else if (!fired_q && !req_held) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                fired_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            winner_q <= '0;
            fired_q  <= 1'b0;
            data_q   <= '0;
            wr_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            winner_q <= winner_d;
            fired_q  <= fired_d;
            data_q   <= data_d;
            wr_en_q  <= wr_en_d;
        end
    end

    assign alloc_o    = (state_q == LOCKED) ? grant_q : '0;
    assign chan_rdy_o = alloc_o & {IN_N{rdy_i}};
    assign data_o     = data_q;
    assign wr_en_o    = wr_en_q;

`ifdef VC_ARB_ERR_EN
    logic err_q, err_d;
    logic is_hdr;

    assign is_hdr = (sel_id == FLIT_ID_W'(HEADER_ID));

    // First fired flit must be a header; any later header is a protocol error
    always_comb begin
        err_d = err_q;
        if (fire && (fired_q ? is_hdr : !is_hdr)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: doc/vc_out_arbiter.md
Name: vc_out_arbiter

Overview:
Output-port stage placed directly downstream of the per-input virtual channels in the switch.
- Collects route requests from IN_N virtual channels targeting one output port.
- Grants exactly one VC per packet using a round-robin arbiter.
- Holds the grant from header to tail and forwards that VC's flits through a registered mux to the next node's FIFO write port.
- Masks downstream backpressure to the granted VC only.

Parameters:
- IN_N, 5, number of requesting virtual channels (≥2).
- FLIT_W, 10, flit width; flit ID is bits [FLIT_W-1 -: FLIT_ID_W].
- FLIT_ID_W, 2, flit-type field width.
- HEADER_ID, 2, ID value of a header flit.
- TAIL_ID, 3, ID value of a tail flit (any other non-header ID is a body flit).

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset, asynchronous, active-low.
- req_i, in, IN_N, bit i = VC i requests this output (its router selected this port).
- data_i, in, IN_N*FLIT_W, flat flit bus; VC i occupies [i*FLIT_W +: FLIT_W].
- data_vld_i, in, IN_N, bit i = flit on VC i slice is valid.
- alloc_o, out, IN_N, one-hot grant (VC chan_alloc); all-zero when idle.
- chan_rdy_o, out, IN_N, per-VC ready: rdy_i for the granted VC, 0 for all others.
- data_o, out, FLIT_W, registered forwarded flit.
- wr_en_o, out, 1, registered write strobe to downstream FIFO.
- rdy_i, in, 1, downstream FIFO not full.

Behaviour:
- Reset values: state=IDLE, grant=0, rr_ptr=0, alloc_o=0, chan_rdy_o=0, data_o=0, wr_en_o=0.
- FSM is one-hot with two states, IDLE and LOCKED.
- IDLE:
  - alloc_o=0.
  - If req_i≠0, winner = first set bit searching from rr_ptr upward with wrap-around modulo IN_N.
  - Register grant=onehot(winner); next state LOCKED.
  - No flit is forwarded in IDLE.
- LOCKED:
  - alloc_o=grant; chan_rdy_o=grant & {IN_N{rdy_i}}.
  - Transfer condition: fire = |(data_vld_i & grant) & rdy_i.
  - On fire: data_o <= granted slice, wr_en_o <= 1. Otherwise wr_en_o <= 0 and data_o holds its value.
  - If fire and the flit ID == TAIL_ID: next state IDLE; rr_ptr <= winner+1 (wraps IN_N-1 → 0); grant cleared.
  - If the granted req_i bit drops before any flit has fired: abandon to IDLE, rr_ptr unchanged.
  - After the first fire, req_i is ignored until the tail.
- Latency: one cycle from the fire cycle to wr_en_o/data_o.
- Arbitration cost: a request seen in IDLE is granted in the next cycle. After a tail, at least one IDLE cycle (bubble) precedes the next grant.
- rdy_i low in LOCKED: no fire, wr_en_o=0, chan_rdy_o=0, and the VC holds its flit.
- Simultaneous requests: round-robin fairness. The VC that just finished has the lowest priority next.
- A header flit firing in LOCKED after the first fire is a protocol error. It is still forwarded; the error is flagged only when the feature below is enabled.
- Reset mid-packet: everything returns to reset values immediately. A partially sent packet is not completed.

Optional Feature:
- Macro VC_ARB_ERR_EN.
- Defined:
  - Adds output err_o (1 bit), reset 0.
  - Set sticky when, in LOCKED, the first fired flit is not HEADER_ID, or a later fired flit is HEADER_ID.
  - Cleared only by reset.
- Not defined: no err_o port and no checking logic.

Test Plan:
- Reset: hold rst_ni=0 with random inputs → alloc_o=0, chan_rdy_o=0, wr_en_o=0, data_o=0.
- Single packet, IN_N=5:
  - Stimulus: req_i=5'b00100; VC2 presents header(ID 2), body(ID 0), tail(ID 3) with rdy_i=1.
  - Response: alloc_o=00100 the cycle after the request; wr_en_o pulses 3 consecutive cycles, each 1 cycle after its fire; alloc_o=0 after the tail.
  - rr_ptr=3.
- Round-robin:
  - Stimulus: req_i=5'b10011 continuously, each VC sending 2-flit packets.
  - Response: grant order 0,1,4,0,1; one idle cycle between packets.
- Backpressure:
  - Stimulus: rdy_i=0 for 3 cycles mid-packet.
  - Response: chan_rdy_o=0 and wr_en_o=0 during the stall; no flit is lost or duplicated; data_o holds its value.
- Abandon:
  - Stimulus: req_i[1] drops while granted and before any data_vld_i.
  - Response: return to IDLE; the next grant is still searched starting from 0.
- With VC_ARB_ERR_EN:
  - Stimulus: a second header flit is sent mid-packet.
  - Response: err_o=1 one cycle later and stays 1 until reset.
